// File: rtl/irq_pkg.sv
// Shared encodings for the 65C02 interrupt entry sequencer: one-hot states, entry kinds,
// bus select codes, vector low bytes and the per-state control decode.
package irq_pkg;

  typedef enum logic [6:0] {
    S_IDLE   = 7'b000_0001,
    S_DUMMY  = 7'b000_0010,
    S_PUSH_H = 7'b000_0100,
    S_PUSH_L = 7'b000_1000,
    S_PUSH_P = 7'b001_0000,
    S_VEC_LO = 7'b010_0000,
    S_VEC_HI = 7'b100_0000
  } state_t;

  typedef enum logic [1:0] {
    K_RST = 2'd0,
    K_NMI = 2'd1,
    K_BRK = 2'd2,
    K_IRQ = 2'd3
  } kind_t;

  localparam logic [3:0] ABH_PCH_CI = 4'b1010;
  localparam logic [3:0] ABH_PAGE01 = 4'b0100;
  localparam logic [3:0] ABH_FF     = 4'b1100;
  localparam logic [3:0] ABH_DB     = 4'b1011;

  localparam logic [1:0] ABL_PC     = 2'b00;
  localparam logic [1:0] ABL_SP     = 2'b01;
  localparam logic [1:0] ABL_VEC    = 2'b10;
  localparam logic [1:0] ABL_VEC1   = 2'b11;

  localparam logic [1:0] DO_PCH     = 2'b00;
  localparam logic [1:0] DO_PCL     = 2'b01;
  localparam logic [1:0] DO_P       = 2'b10;

  localparam logic [7:0] VEC_NMI    = 8'hFA;
  localparam logic [7:0] VEC_RST    = 8'hFC;
  localparam logic [7:0] VEC_IRQ    = 8'hFE;

  typedef struct packed {
    logic [3:0] abh_op;
    logic [1:0] abl_sel;
    logic [7:0] vec_lo;
    logic       we;
    logic [1:0] do_sel;
    logic       b_bit;
    logic       sp_dec;
    logic       set_i;
    logic       ld_pc;
    logic       inc_pc;
  } ctrl_t;

  function automatic logic [7:0] vector_lo(input kind_t kind);
    case (kind)
      K_NMI:   vector_lo = VEC_NMI;
      K_RST:   vector_lo = VEC_RST;
      default: vector_lo = VEC_IRQ;
    endcase
  endfunction

  // BRK and IRQ share the FE vector and are the only entries an NMI can hijack.
  function automatic logic is_maskable_kind(input kind_t kind);
    is_maskable_kind = (kind == K_BRK) || (kind == K_IRQ);
  endfunction

  // Reset entry runs the push cycles as reads so the stack is not disturbed.
  function automatic ctrl_t push_ctrl(input ctrl_t base, input kind_t kind, input logic [1:0] sel);
    ctrl_t c;
    c         = base;
    c.abh_op  = ABH_PAGE01;
    c.abl_sel = ABL_SP;
    c.sp_dec  = 1'b1;
    c.we      = (kind != K_RST);
    c.do_sel  = sel;
    return c;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t state, input kind_t kind);
    ctrl_t c;
    c         = '0;
    c.abh_op  = ABH_PCH_CI;
    c.abl_sel = ABL_PC;
    c.do_sel  = DO_PCH;
    c.vec_lo  = vector_lo(kind);
    c.b_bit   = (kind == K_BRK);
    case (state)
      S_IDLE:   c.inc_pc = 1'b0;
      S_DUMMY:  c.inc_pc = (kind == K_BRK);
      S_PUSH_H: c = push_ctrl(c, kind, DO_PCH);
      S_PUSH_L: c = push_ctrl(c, kind, DO_PCL);
      S_PUSH_P: c = push_ctrl(c, kind, DO_P);
      S_VEC_LO: begin
        c.abh_op  = ABH_FF;
        c.abl_sel = ABL_VEC;
        c.set_i   = 1'b1;
      end
      S_VEC_HI: begin
        c.abh_op  = ABH_DB;
        c.abl_sel = ABL_VEC1;
        c.ld_pc   = 1'b1;
      end
      default:  c.inc_pc = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nmi_edge.sv
// NMI input synchroniser and rising-edge latch. A new edge wins over a same-cycle
// clear, so an NMI arriving while the previous one is consumed is never lost.
module nmi_edge #(
  parameter int NMI_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic nmi,
  input  logic clr,
  output logic lat
);

  logic nmi_s;
  logic nmi_prev;
  logic rise;

  if (NMI_SYNC == 0) begin : g_direct
    assign nmi_s = nmi;
  end else begin : g_sync
    logic [NMI_SYNC-1:0] chain;

    // Synchroniser chain; keeps running regardless of RDY.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chain <= '0;
      end else begin
        chain[0] <= nmi;
        for (int i = 1; i < NMI_SYNC; i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign nmi_s = chain[NMI_SYNC-1];
  end

  assign rise = nmi_s & ~nmi_prev;

  // Edge history and the pending-NMI latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_prev <= 1'b0;
      lat      <= 1'b0;
    end else begin
      nmi_prev <= nmi_s;
      if (rise) begin
        lat <= 1'b1;
      end else if (clr) begin
        lat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_vector_seq.sv
// Interrupt entry sequencer for the 65C02 microcode core: arbitrates RESET/NMI/BRK/IRQ at
// instruction boundaries and steps the 7-cycle dummy/push/vector-fetch entry.
module irq_vector_seq
  import irq_pkg::*;
#(
  parameter int NMI_SYNC = 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       RDY,
  input  logic       sync,
  input  logic       NMI,
  input  logic       IRQ,
  input  logic       BRK,
  input  logic       I_flag,
  output logic [3:0] abh_op,
  output logic [1:0] abl_sel,
  output logic [7:0] vec_lo,
  output logic       WE,
  output logic [1:0] do_sel,
  output logic       b_bit,
  output logic       sp_dec,
  output logic       set_i,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       busy
);

  state_t state;
  kind_t  kind;
  kind_t  winner;
  logic   pend_rst;
  logic   nmi_lat;
  logic   nmi_clr;
  logic   req_nmi;
  logic   req_brk;
  logic   req_irq;
  logic   start;
  logic   hijack;
  ctrl_t  ctrl;

  nmi_edge #(
    .NMI_SYNC(NMI_SYNC)
  ) u_nmi_edge (
    .clk(clk),
    .rst(RST),
    .nmi(NMI),
    .clr(nmi_clr),
    .lat(nmi_lat)
  );

  // Only a pending reset may start away from an opcode fetch.
  assign req_nmi = sync & nmi_lat;
  assign req_brk = sync & BRK;
  assign req_irq = sync & IRQ & ~I_flag;
  assign start   = pend_rst | req_nmi | req_brk | req_irq;

  // Fixed priority RESET > NMI > BRK > IRQ.
  always_comb begin
    if (pend_rst) begin
      winner = K_RST;
    end else if (req_nmi) begin
      winner = K_NMI;
    end else if (req_brk) begin
      winner = K_BRK;
    end else begin
      winner = K_IRQ;
    end
  end

  // A late NMI redirects a BRK/IRQ entry to its vector; the pushed B bit is already gone.
  assign hijack  = is_maskable_kind(kind) & nmi_lat;
  assign nmi_clr = RDY & (state == S_PUSH_P) & ((kind == K_NMI) | hijack);

  // Sequence state, latched entry kind and pending reset; frozen while RDY is low.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      kind     <= K_RST;
      pend_rst <= 1'b1;
    end else if (RDY) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_DUMMY;
            kind     <= winner;
            pend_rst <= 1'b0;
          end
        end
        S_DUMMY:  state <= S_PUSH_H;
        S_PUSH_H: state <= S_PUSH_L;
        S_PUSH_L: state <= S_PUSH_P;
        S_PUSH_P: begin
          state <= S_VEC_LO;
          if (hijack) begin
            kind <= K_NMI;
          end
        end
        S_VEC_LO: state <= S_VEC_HI;
        S_VEC_HI: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign ctrl    = decode_ctrl(state, kind);
  assign abh_op  = ctrl.abh_op;
  assign abl_sel = ctrl.abl_sel;
  assign vec_lo  = ctrl.vec_lo;
  assign WE      = ctrl.we;
  assign do_sel  = ctrl.do_sel;
  assign b_bit   = ctrl.b_bit;
  assign sp_dec  = ctrl.sp_dec;
  assign set_i   = ctrl.set_i;
  assign ld_pc   = ctrl.ld_pc;
  assign inc_pc  = ctrl.inc_pc;

  // The arbitration cycle itself already counts as busy.
  assign busy = (state == S_IDLE) ? start : 1'b1;

endmodule
